ps2_key_tracker: RTL
====================

// Module: ps2_key_tracker
// PURPOSE
//  Sequences the raw PS/2 scan-code byte stream into game key state.
//  Sits between the PS/2 byte receiver and the game logic.
//  Decodes E0/F0 prefixes, keeps a held-key bitmap for 8 mapped game keys,
//  and queues press/release events in a small FIFO with a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH   4       event queue depth, power of 2, >=2
//  TIMEOUT_CYC  100000  idle cycles (2 ms @ 50 MHz) before a dangling prefix is dropped; 0 = never
// PORTS
//  Clk          in   1  system clock; the only clock
//  Reset_n      in   1  asynchronous, active-low reset
//  byte_valid   in   1  one-cycle strobe: byte_data holds a complete received byte
//  byte_data    in   8  received scan-code byte
//  key_held     out  8  bit i = mapped key i currently held
//  evt_valid    out  1  event FIFO not empty
//  evt_ready    in   1  consumer accepts head event when evt_valid && evt_ready
//  evt_key      out  3  head event key index
//  evt_press    out  1  head event: 1 = press, 0 = release
//  overflow     out  1  sticky: an event was dropped
//  clr_overflow in   1  clears overflow
// BEHAVIOUR
//  Clocking/reset: one clock, Clk; reset Reset_n is asynchronous and active-low.
//  Reset values: state IDLE, key_held 0, FIFO empty, evt_valid 0, evt_key 0, evt_press 0, overflow 0.
//  Reset asserted mid-sequence discards any pending prefix and all queued events.
//  Key map (index:code): 0:1D W, 1:1C A, 2:1B S, 3:23 D, 4:29 Space, 5:76 Esc,
//   6:E0 75 Up, 7:E0 72 Down. All other codes are unmapped and ignored.
//  FSM states IDLE, EXT, BRK, EXT_BRK. State advances only on byte_valid.
//   IDLE:    E0->EXT, F0->BRK, AA/00/FF->clear key_held (no events), FA/FE->ignore,
//            other->make(plain).
//   EXT:     F0->EXT_BRK, E0->EXT, other->make(ext), then IDLE.
//   BRK:     E0->EXT_BRK, F0->BRK, other->break(plain), then IDLE.
//   EXT_BRK: F0/E0->EXT_BRK, other->break(ext), then IDLE.
//  make: mapped and not held -> set held bit, push {key,1}.
//   Mapped and already held (typematic repeat) -> no change, no event.
//  break: mapped and held -> clear held bit, push {key,0}; otherwise nothing.
//  Latency: byte_valid in cycle N -> key_held and FIFO contents updated at N+1.
//   If the FIFO was empty, evt_valid is high at N+1.
//  FIFO is first-word fall-through. Pop happens when evt_valid && evt_ready.
//  Full with no pop: pushed event dropped, overflow<=1, key_held still updated.
//  Full with simultaneous pop: push succeeds, no overflow.
//  Empty: evt_ready ignored; evt_key/evt_press hold their last value.
//  overflow set and clr_overflow in the same cycle: set wins.
//  Timeout: counter cleared on every byte_valid and in IDLE.
//   In EXT/BRK/EXT_BRK, reaching TIMEOUT_CYC cycles -> IDLE, pending byte discarded.
//   Counter saturates; no wrap-around.
//  key_held bits change only via make/break or the AA/00/FF clear.
// STRUCTURE
//  ps2_pkg: scan-code constants (E0, F0, AA, FA, FE), key-index localparams,
//   8-entry key map table, tracker_state_t enum, evt_t struct {key[2:0], press}.
//  Sub-module ps2_evt_fifo: parameterised FWFT FIFO of evt_t with full/empty;
//   pointers are one bit wider than the address for full/empty detection.
//  Top level holds the FSM, timeout counter, map lookup, key_held register and overflow logic.
// TESTING
//  1D -> key_held=01, one event {0,1}; then F0 1D -> key_held=00, event {0,0}.
//  E0 75, E0 75, E0 F0 75 -> key_held[6] 1 then 0.
//   Exactly two events {6,1},{6,0}; the repeat adds none.
//  evt_ready=0; bytes 1D 1C 1B 23 29 (5 presses, depth 4) -> 4 events queued.
//   overflow=1 and key_held=1F. clr_overflow -> overflow=0.
//  FIFO full, push and pop in the same cycle -> count stays 4, overflow stays 0.
//   Head advances by one entry.
//  TIMEOUT_CYC=16: F0, wait 16 idle cycles, then 1D -> treated as make.
//   Result: press {0,1}, not a release.
//  Hold 1D and 29, then byte AA -> key_held=00, no new events.
//   Reset_n low mid E0 -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, game key map and types for the PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam int NUM_KEYS  = 8;
  localparam int KEY_W     = 0;
  localparam int KEY_A     = 1;
  localparam int KEY_S     = 2;
  localparam int KEY_D     = 3;
  localparam int KEY_SPACE = 4;
  localparam int KEY_ESC   = 5;
  localparam int KEY_UP    = 6;
  localparam int KEY_DOWN  = 7;

  // Entry i is the code for key index i; KEY_EXT marks codes that need the E0 prefix.
  localparam logic [NUM_KEYS-1:0][7:0] KEY_CODE =
    {8'h72, 8'h75, 8'h76, 8'h29, 8'h23, 8'h1B, 8'h1C, 8'h1D};
  localparam logic [NUM_KEYS-1:0] KEY_EXT = (8'b1 << KEY_UP) | (8'b1 << KEY_DOWN);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} tracker_state_t;

  typedef struct packed {
    logic [2:0] key;
    logic       press;
  } evt_t;

  // Returns {hit, index}; hit is 0 for unmapped codes.
  function automatic logic [3:0] key_lookup(input logic [7:0] code, input logic ext);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (KEY_CODE[i] == code && KEY_EXT[i] == ext) r = {1'b1, 3'(i)};
    return r;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word fall-through event FIFO; the head output holds its last value while empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty
);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  evt_t          mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  evt_t          last;
  logic          do_pop, do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written when full, so push may proceed.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      last <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (!empty)  last <= mem[rptr[AW-1:0]];
    end

  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= push_data;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code sequencer: prefix FSM, held-key bitmap and press/release event queue.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [7:0] key_held,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_key,
  output logic       evt_press,
  output logic       overflow,
  input  logic       clr_overflow
);
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

  tracker_state_t state;
  logic [TW-1:0]  tcnt;
  logic           is_ext, is_brk, is_clr, is_ign;
  logic           do_make, do_brk, do_clr, ext;
  logic           hit;
  logic [2:0]     kidx;
  logic           push, pop, full, empty;
  evt_t           push_evt, head;

  assign is_ext = (byte_data == SC_EXT);
  assign is_brk = (byte_data == SC_BRK);
  assign is_clr = (byte_data == SC_BAT) || (byte_data == SC_ERR0) || (byte_data == SC_ERR1);
  assign is_ign = (byte_data == SC_ACK) || (byte_data == SC_RESEND);

  always_comb begin
    do_make = 1'b0;
    do_brk  = 1'b0;
    do_clr  = 1'b0;
    ext     = 1'b0;
    if (byte_valid && !is_ext && !is_brk)
      unique case (state)
        ST_IDLE: begin
          do_clr  = is_clr;
          do_make = !is_clr && !is_ign;
        end
        ST_EXT:  begin do_make = 1'b1; ext = 1'b1; end
        ST_BRK:  do_brk = 1'b1;
        default: begin do_brk = 1'b1; ext = 1'b1; end
      endcase
    {hit, kidx} = key_lookup(byte_data, ext);
    // Repeated makes of a held key and breaks of a released key are silent.
    push     = hit && ((do_make && !key_held[kidx]) || (do_brk && key_held[kidx]));
    push_evt = '{key: kidx, press: do_make};
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else if (byte_valid) begin
      tcnt <= '0;
      unique case (state)
        ST_IDLE: state <= is_ext ? ST_EXT : is_brk ? ST_BRK : ST_IDLE;
        ST_EXT:  state <= is_brk ? ST_EXT_BRK : is_ext ? ST_EXT : ST_IDLE;
        ST_BRK:  state <= is_ext ? ST_EXT_BRK : is_brk ? ST_BRK : ST_IDLE;
        default: state <= (is_ext || is_brk) ? ST_EXT_BRK : ST_IDLE;
      endcase
    end else if (state == ST_IDLE) begin
      tcnt <= '0;
    end else if (TIMEOUT_CYC != 0) begin
      // Dangling prefix: give up once the idle budget is spent.
      if (tcnt == TO_LAST) begin
        state <= ST_IDLE;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end

  assign pop = !empty && evt_ready;

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      key_held <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_clr)    key_held       <= '0;
      else if (push) key_held[kidx] <= do_make;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
    end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .push     (push),
    .push_data(push_evt),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign evt_valid = !empty;
  assign evt_key   = head.key;
  assign evt_press = head.press;

endmodule
